// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver that assembles 0x55 ... 0x0D 0x0A command frames into an 88-bit word.
// Optional idle timeout in COLLECT is compiled in with `define UART_RX_TIMEOUT_EN.
module uart_frame_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [87:0] receive_data,
  output logic [3:0]  receive_data_bytes,
  output logic        RX_interrupt,
  input  logic        RX_interrupt_clear,
  output logic        frame_error,
  output logic        overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(HALF_BIT - 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
  typedef enum logic {F_HUNT, F_COLLECT} frame_state_t;

  logic             r_rx_s1;
  logic             r_rx_s2;
  logic             r_rx_d;
  logic             w_fall;

  bit_state_t       r_bit_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_byte;
  logic             r_byte_vld;
  logic             r_stop_err;

  frame_state_t     r_frame_state;
  logic [87:0]      r_buf;
  logic [3:0]       r_count;
  logic [87:0]      r_data;
  logic [3:0]       r_bytes;
  logic             r_irq;
  logic             r_ferr;
  logic             r_ovr;

  logic [3:0]       w_next_count;
  logic [87:0]      w_next_buf;
  logic             w_term;
  logic             w_can_latch;
  logic             w_timeout;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= uart_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  assign w_fall = r_rx_d & ~r_rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_state <= B_IDLE;
      r_bit_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_byte      <= '0;
      r_byte_vld  <= 1'b0;
      r_stop_err  <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      r_stop_err <= 1'b0;
      case (r_bit_state)
        B_IDLE: begin
          if (w_fall) begin
            r_bit_state <= B_START;
            r_bit_cnt   <= '0;
          end
        end
        B_START: begin
          if (r_bit_cnt == LAST_HALF) begin
            r_bit_cnt <= '0;
            if (!r_rx_s2) begin
              r_bit_state <= B_DATA;
              r_bit_idx   <= '0;
            end else begin
              r_bit_state <= B_IDLE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (r_bit_cnt == LAST_FULL) begin
            r_bit_cnt <= '0;
            r_shift   <= {r_rx_s2, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_bit_state <= B_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        B_STOP: begin
          if (r_bit_cnt == LAST_FULL) begin
            r_bit_cnt   <= '0;
            r_bit_state <= B_IDLE;
            if (r_rx_s2) begin
              r_byte     <= r_shift;
              r_byte_vld <= 1'b1;
            end else begin
              r_stop_err <= 1'b1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        default: r_bit_state <= B_IDLE;
      endcase
    end
  end

  // While collecting, r_buf[7:0] always holds the previous byte of this frame.
  assign w_next_count = r_count + 4'd1;
  assign w_next_buf   = {r_buf[79:0], r_byte};
  assign w_term       = (r_byte == 8'h0A) && (r_buf[7:0] == 8'h0D) && (w_next_count >= 4'd3);
  assign w_can_latch  = !r_irq || RX_interrupt_clear;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_CYCLES = 16 * CLKS_PER_BIT;
  localparam int TO_W      = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TO_CYCLES);

  logic [TO_W-1:0] r_to_cnt;

  // Saturates at the limit; fires only while no byte is being received.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if ((r_frame_state != F_COLLECT) || r_byte_vld) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_LIMIT) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_frame_state == F_COLLECT) && (r_to_cnt == TO_LIMIT) &&
                     (r_bit_state == B_IDLE);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_state <= F_HUNT;
      r_buf         <= '0;
      r_count       <= '0;
      r_data        <= '0;
      r_bytes       <= '0;
      r_irq         <= 1'b0;
      r_ferr        <= 1'b0;
      r_ovr         <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      if (RX_interrupt_clear) begin
        r_irq <= 1'b0;
      end
      if (r_stop_err) begin
        r_ferr        <= 1'b1;
        r_frame_state <= F_HUNT;
        r_count       <= '0;
      end else if (r_byte_vld) begin
        case (r_frame_state)
          F_HUNT: begin
            if (r_byte == 8'h55) begin
              r_buf         <= {80'd0, 8'h55};
              r_count       <= 4'd1;
              r_frame_state <= F_COLLECT;
            end
          end
          F_COLLECT: begin
            if (w_term) begin
              if (w_can_latch) begin
                r_data  <= w_next_buf;
                r_bytes <= w_next_count;
                r_irq   <= 1'b1;
              end else begin
                r_ovr <= 1'b1;
              end
              r_frame_state <= F_HUNT;
              r_count       <= '0;
            end else if (w_next_count == 4'd11) begin
              r_ferr        <= 1'b1;
              r_frame_state <= F_HUNT;
              r_count       <= '0;
            end else begin
              r_buf   <= w_next_buf;
              r_count <= w_next_count;
            end
          end
          default: r_frame_state <= F_HUNT;
        endcase
      end else if (w_timeout) begin
        r_ferr        <= 1'b1;
        r_frame_state <= F_HUNT;
        r_count       <= '0;
      end
    end
  end

  assign receive_data       = r_data;
  assign receive_data_bytes = r_bytes;
  assign RX_interrupt       = r_irq;
  assign frame_error        = r_ferr;
  assign overrun            = r_ovr;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: directed frames in, monitor checks frames, errors and overruns.
module tb_uart_frame_rx;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int CPB      = CLK_FREQ / BAUD;

  localparam logic [1:0] K_FRAME = 2'd0;
  localparam logic [1:0] K_ERR   = 2'd1;
  localparam logic [1:0] K_OVR   = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [87:0] data;
    logic [3:0]  bytes;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        clr = 1'b0;
  logic [87:0] receive_data;
  logic [3:0]  receive_data_bytes;
  logic        RX_interrupt;
  logic        frame_error;
  logic        overrun;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_frame_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .uart_rx            (uart_rx),
    .receive_data       (receive_data),
    .receive_data_bytes (receive_data_bytes),
    .RX_interrupt       (RX_interrupt),
    .RX_interrupt_clear (clr),
    .frame_error        (frame_error),
    .overrun            (overrun)
  );

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [87:0] data, input int n);
    exp_t e;
    e.kind  = kind;
    e.data  = data;
    e.bytes = 4'(n);
    q.push_back(e);
  endtask

  task automatic handle(input logic [1:0] kind, input string name);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected event, nothing expected", name);
      return;
    end
    e = q.pop_front();
    chk({name, "_kind"}, 88'(kind), 88'(e.kind));
    if (kind == e.kind && kind == K_FRAME) begin
      chk({name, "_data"}, receive_data, e.data);
      chk({name, "_bytes"}, 88'(receive_data_bytes), 88'(e.bytes));
    end else if (kind == e.kind && kind == K_OVR) begin
      chk({name, "_held_data"}, receive_data, e.data);
    end
  endtask

  logic        prev_irq = 1'b0;
  logic [87:0] prev_data = '0;
  logic [3:0]  prev_bytes = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_error) handle(K_ERR, "frame_error");
      if (overrun) handle(K_OVR, "overrun");
      if (RX_interrupt && (!prev_irq || receive_data != prev_data ||
                           receive_data_bytes != prev_bytes))
        handle(K_FRAME, "frame");
    end
    prev_irq   = RX_interrupt;
    prev_data  = receive_data;
    prev_bytes = receive_data_bytes;
  end

  task automatic bit_out(input logic v);
    uart_rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
  endtask

  // Stop-bit midpoint of the last byte sits 152 cycles after its start edge; completion is 4 later.
  task automatic send_vec(input logic [87:0] v, input int n, input bit clr_last);
    for (int i = n - 1; i >= 0; i--) begin
      if (i == 0 && clr_last) begin
        fork
          begin
            repeat (155) @(posedge clk);
            #1 clr = 1'b1;
            @(posedge clk);
            #1 clr = 1'b0;
          end
        join_none
      end
      send_byte(v[8*i +: 8], 1'b1);
    end
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d expected events never seen", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, "_data"}, receive_data, 88'd0);
    chk({name, "_bytes"}, 88'(receive_data_bytes), 88'd0);
    chk({name, "_irq"}, 88'(RX_interrupt), 88'd0);
    chk({name, "_ferr"}, 88'(frame_error), 88'd0);
    chk({name, "_ovr"}, 88'(overrun), 88'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Full-length frame, then acknowledge.
    push(K_FRAME, 88'h555D01AABBBBCCDD000D0A, 11);
    send_vec(88'h555D01AABBBBCCDD000D0A, 11, 1'b0);
    wait_drain("t1");
    chk("t1_irq_set", 88'(RX_interrupt), 88'd1);
    pulse_clear();
    chk("t1_irq_cleared", 88'(RX_interrupt), 88'd0);
    chk("t1_data_held", receive_data, 88'h555D01AABBBBCCDD000D0A);
    chk("t1_bytes_held", 88'(receive_data_bytes), 88'd11);
    pulse_clear();
    chk("idle_clear_irq", 88'(RX_interrupt), 88'd0);
    chk("idle_clear_data", receive_data, 88'h555D01AABBBBCCDD000D0A);

    // Leading noise bytes ignored; short frame right-aligned.
    push(K_FRAME, 88'h55010D0A, 4);
    send_vec(88'h00AA55010D0A, 6, 1'b0);
    wait_drain("t2");
    pulse_clear();

    // Lone 0x0D is payload.
    push(K_FRAME, 88'h550D410D0A, 5);
    send_vec(88'h550D410D0A, 5, 1'b0);
    wait_drain("t3");
    pulse_clear();

    // Overlength frame, then minimum-length frame.
    push(K_ERR, 88'd0, 0);
    send_vec(88'h5511111111111111111111, 11, 1'b0);
    wait_drain("t4_err");
    chk("t4_no_irq", 88'(RX_interrupt), 88'd0);
    push(K_FRAME, 88'h550D0A, 3);
    send_vec(88'h550D0A, 3, 1'b0);
    wait_drain("t4_min");
    pulse_clear();

    // Bad stop bit mid-frame; stray terminator afterwards is ignored.
    push(K_ERR, 88'd0, 0);
    send_vec(88'h5501, 2, 1'b0);
    send_byte(8'h02, 1'b0);
    bit_out(1'b1);
    bit_out(1'b1);
    wait_drain("t5_err");
    chk("t5_no_irq", 88'(RX_interrupt), 88'd0);
    send_vec(88'h0D0A, 2, 1'b0);
    push(K_FRAME, 88'h55020D0A, 4);
    send_vec(88'h55020D0A, 4, 1'b0);
    wait_drain("t5_frame");

    // Overrun while the interrupt is pending, then clear coincident with completion.
    push(K_OVR, 88'h55020D0A, 4);
    send_vec(88'h55030D0A, 4, 1'b0);
    wait_drain("t6_ovr");
    chk("t6_ovr_irq", 88'(RX_interrupt), 88'd1);
    chk("t6_ovr_bytes", 88'(receive_data_bytes), 88'd4);
    push(K_FRAME, 88'h5504050D0A, 5);
    send_vec(88'h5504050D0A, 5, 1'b1);
    wait_drain("t6_coincident");
    chk("t6_coincident_irq", 88'(RX_interrupt), 88'd1);
    pulse_clear();

    // Reset in the middle of a byte discards everything.
    send_byte(8'h55, 1'b1);
    uart_rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("midreset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push(K_FRAME, 88'h55070D0A, 4);
    send_vec(88'h55070D0A, 4, 1'b0);
    wait_drain("t7");
    pulse_clear();

`ifdef UART_RX_TIMEOUT_EN
    push(K_ERR, 88'd0, 0);
    send_vec(88'h5501, 2, 1'b0);
    repeat (20 * CPB) @(posedge clk);
    #1;
    wait_drain("t8_timeout");
    chk("t8_no_irq", 88'(RX_interrupt), 88'd0);
`endif

    repeat (50) @(posedge clk);
    #1;
    chk("final_queue_empty", 88'(q.size()), 88'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
